axis_frame_scheduler: RTL
=========================

// Module: axis_frame_scheduler
// PURPOSE
//  Schedules N_SRC AXI-stream frame sources (e.g. file-backed stimulus generators) onto one master stream.
//  Pulses the sources' start inputs, then grants the output round-robin with frame granularity.
//  A grant is held from first beat to tlast, so frames never interleave.
//  Sits between the per-channel stimulus generators and the downstream datapath under test.
// PARAMETERS
//  Width    32    tdata width per source and on master
//  N_SRC    4     number of sources (2..16)
//  TIMEOUT  1024  source-stall cycles before a frame is aborted (only with STREAM_SCHED_TIMEOUT_EN)
// PORTS
//  i_sys_clk     in   1            system clock
//  i_sys_rst     in   1            reset, asynchronous, active-high
//  i_enable      in   1            level; low = no new grants, current frame completes
//  o_src_start   out  N_SRC        one-cycle start pulse to all sources
//  i_src_tdata   in   N_SRC*Width  source data, source k at [k*Width +: Width]
//  i_src_tvalid  in   N_SRC        source valid
//  i_src_tlast   in   N_SRC        source end-of-frame
//  o_src_tready  out  N_SRC        source ready
//  o_m_tdata     out  Width        master data
//  o_m_tvalid    out  1            master valid
//  o_m_tlast     out  1            master end-of-frame
//  i_m_tready    in   1            master ready
//  o_grant       out  N_SRC        one-hot current grant, 0 when none
//  o_busy        out  1            1 when state != IDLE
//  o_frame_cnt   out  32           frames completed with tlast; wraps 2^32-1 -> 0
//  o_timeout     out  1            one-cycle abort pulse
// BEHAVIOUR
//  Reset values: state IDLE; o_grant, o_src_start, o_src_tready, o_m_* = 0; o_frame_cnt 0;
//   o_timeout 0; rr pointer = N_SRC-1, so source 0 has first priority.
//  Reset asserted mid-frame drops the frame immediately: no tlast, no count.
//  FSM: IDLE -> ARB -> XFER -> ARB | IDLE.
//  IDLE: when i_enable=1, go to ARB and drive o_src_start = all ones for exactly that cycle.
//  ARB:
//   - i_enable=0: go to IDLE.
//   - Else pick the first k with i_src_tvalid[k]=1, searching from ptr+1 upward with wrap.
//   - Register o_grant = onehot(k) and go to XFER.
//   - No valid source: stay in ARB.
//   - Arbitration latency is 1 cycle; the master is idle during ARB.
//  XFER: combinational mux on granted source g:
//   - o_m_tdata/tvalid/tlast = source g.
//   - o_src_tready[g] = i_m_tready; every other source's tready = 0.
//   - A beat is tvalid & tready on the master.
//   - Beat with tlast: ptr <= g, o_grant <= 0, o_frame_cnt += 1, next state ARB.
//   - Other sources' tvalid never preempts the grant.
//  Back-to-back frames from different sources are separated by the 1-cycle ARB bubble.
//  A single valid source is regranted every frame.
//  i_enable falling mid-frame has no effect until tlast; then go to IDLE.
//  Re-enabling from IDLE issues a new o_src_start pulse.
// CONFIGURATION
//  STREAM_SCHED_TIMEOUT_EN defined:
//   - In XFER, count cycles where granted i_src_tvalid=0; clear the count on every beat.
//   - Downstream stall (tvalid=1, tready=0) does not count.
//   - When the count reaches TIMEOUT: pulse o_timeout for 1 cycle, o_grant <= 0, ptr <= g, go to ARB.
//   - No tlast is emitted and o_frame_cnt is unchanged.
//  Not defined: no counter; XFER waits indefinitely; o_timeout tied 0.
// TESTING
//  T1 reset/start:
//   - Release reset, i_enable=1 -> o_src_start = all ones for 1 cycle.
//   - All outputs 0 before then; o_busy=1 after.
//  T2 round robin:
//   - 4 sources always valid, 8-beat frames, tready=1.
//   - Grant order 0,1,2,3,0; one bubble between frames; o_frame_cnt=5 after 5 frames.
//  T3 no interleave:
//   - Source 2 mid-frame, source 0 raises tvalid.
//   - Grant stays 2 until tlast, then goes to 0 (wrap).
//   - o_src_tready[0]=0 throughout.
//  T4 backpressure:
//   - Random i_m_tready 50% -> every source beat appears once, in order, with tlast on beat 8.
//   - No timeout with macro on.
//  T5 disable/reset mid-frame:
//   - i_enable=0 at beat 3 -> frame completes, state IDLE.
//   - Reset at beat 3 -> outputs 0 next edge, o_frame_cnt=0.
//  T6 timeout (macro on, TIMEOUT=16):
//   - Granted source drops tvalid after beat 2.
//   - o_timeout pulses at stall cycle 16; next source granted; o_frame_cnt unchanged.

Source files
------------

// File: rtl/axis_frame_scheduler.sv
// Round-robin scheduler that arbitrates N_SRC AXI-stream sources onto one master stream, one whole frame at a time.
// Define STREAM_SCHED_TIMEOUT_EN to abort a granted frame after TIMEOUT source-stall cycles.
//
// state | meaning
// IDLE  | disabled, no grant, master idle
// ARB   | choosing next source; master idle for this cycle
// XFER  | granted source owns the master until its tlast beat
module axis_frame_scheduler #(
    parameter int Width   = 32,
    parameter int N_SRC   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                   i_sys_clk,
    input  logic                   i_sys_rst,
    input  logic                   i_enable,
    output logic [N_SRC-1:0]       o_src_start,
    input  logic [N_SRC*Width-1:0] i_src_tdata,
    input  logic [N_SRC-1:0]       i_src_tvalid,
    input  logic [N_SRC-1:0]       i_src_tlast,
    output logic [N_SRC-1:0]       o_src_tready,
    output logic [Width-1:0]       o_m_tdata,
    output logic                   o_m_tvalid,
    output logic                   o_m_tlast,
    input  logic                   i_m_tready,
    output logic [N_SRC-1:0]       o_grant,
    output logic                   o_busy,
    output logic [31:0]            o_frame_cnt,
    output logic                   o_timeout
);

    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_XFER} state_t;

    state_t            state_q, state_d;
    logic [N_SRC-1:0]  grant_q, grant_d;
    logic [IW-1:0]     gidx_q, gidx_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [31:0]       frame_cnt_q, frame_cnt_d;
    logic              start_q, start_d;
    logic              timeout_q, timeout_d;

    logic [IW-1:0]     hi_idx, lo_idx, pick_idx;
    logic              hi_vld, lo_vld;
    logic              beat;
    logic              stall_abort;

    // Lowest valid index above the pointer wins; otherwise wrap to the lowest valid index overall.
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        hi_vld = 1'b0;
        lo_vld = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (i_src_tvalid[i]) begin
                lo_idx = IW'(i);
                lo_vld = 1'b1;
                if (i > int'(ptr_q)) begin
                    hi_idx = IW'(i);
                    hi_vld = 1'b1;
                end
            end
        end
        pick_idx = hi_vld ? hi_idx : lo_idx;
    end

    always_comb begin
        o_m_tdata    = '0;
        o_m_tvalid   = 1'b0;
        o_m_tlast    = 1'b0;
        o_src_tready = '0;
        if (state_q == ST_XFER) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (gidx_q == IW'(i)) begin
                    o_m_tdata       = i_src_tdata[i*Width +: Width];
                    o_m_tvalid      = i_src_tvalid[i];
                    o_m_tlast       = i_src_tlast[i];
                    o_src_tready[i] = i_m_tready;
                end
            end
        end
    end

    assign beat = o_m_tvalid & i_m_tready;

`ifdef STREAM_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_q, tmo_d;

    // Down-counter reloads outside XFER and on every beat; only source-side stalls decrement it.
    always_comb begin
        tmo_d       = tmo_q;
        stall_abort = 1'b0;
        if (state_q != ST_XFER || beat) begin
            tmo_d = TW'(TIMEOUT - 1);
        end else if (!o_m_tvalid) begin
            if (tmo_q == '0) begin
                stall_abort = 1'b1;
            end else begin
                tmo_d = tmo_q - 1'b1;
            end
        end
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            tmo_q <= TW'(TIMEOUT - 1);
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign stall_abort = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        ptr_d       = ptr_q;
        frame_cnt_d = frame_cnt_q;
        start_d     = 1'b0;
        timeout_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_enable) begin
                    state_d = ST_ARB;
                    start_d = 1'b1;
                end
            end
            ST_ARB: begin
                if (!i_enable) begin
                    state_d = ST_IDLE;
                end else if (lo_vld) begin
                    for (int i = 0; i < N_SRC; i++) begin
                        grant_d[i] = (pick_idx == IW'(i));
                    end
                    gidx_d  = pick_idx;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (beat && o_m_tlast) begin
                    grant_d     = '0;
                    ptr_d       = gidx_q;
                    frame_cnt_d = frame_cnt_q + 32'd1;
                    state_d     = i_enable ? ST_ARB : ST_IDLE;
                end else if (stall_abort) begin
                    grant_d   = '0;
                    ptr_d     = gidx_q;
                    timeout_d = 1'b1;
                    state_d   = ST_ARB;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            ptr_q       <= IW'(N_SRC - 1);
            frame_cnt_q <= '0;
            start_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            ptr_q       <= ptr_d;
            frame_cnt_q <= frame_cnt_d;
            start_q     <= start_d;
            timeout_q   <= timeout_d;
        end
    end

    assign o_src_start = {N_SRC{start_q}};
    assign o_grant     = grant_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_frame_cnt = frame_cnt_q;
    assign o_timeout   = timeout_q;

endmodule
